intersection_scheduler: RTL and testbench
=========================================

INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 SHALL have parameter T_HWG_MIN, default 16, meaning highway minimum-green duration in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter T_Y, default 4, meaning yellow duration in cycles for both roads (legal range 1..255).
REQ-003 SHALL have parameter T_CRG, default 8, meaning country-road green duration in cycles (legal range 1..255).
REQ-004 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port car_det  input  1  country-road vehicle sensor; asynchronous level.
REQ-007 SHALL have port HW_LED  output  3  highway lamps: 3'b100 green, 3'b010 yellow, 3'b001 red.
REQ-008 SHALL have port CR_Ena  output  1  one-cycle start strobe to the country-road light controller.
REQ-009 SHALL have port time_out  output  1  one-cycle phase-advance strobe to the country-road light controller.
REQ-010 SHALL have port phase  output  3  current scheduler state code, for debug.

Function
REQ-011 SHALL synchronise car_det through two flops; the synchronised level (car_s) lags car_det by 2 cycles.
REQ-012 SHALL implement the states S_HWG=0, S_HWY=1, S_START=2, S_CRG=3 and S_CRY=4; phase SHALL equal the state code.
REQ-013 SHALL use a down-counter (8 bits) that loads duration-1 on entry to each timed state, decrements each cycle, and holds at 0; "expired" SHALL mean counter==0.
REQ-014 SHALL set car_req when car_s==1 in S_HWG, clear it on entry to S_START, and ignore car_s in all other states.
REQ-015 SHALL transition S_HWG->S_HWY on the edge where expired && car_req; otherwise it SHALL stay in S_HWG indefinitely.
REQ-016 SHALL transition S_HWY->S_START when expired, so that S_HWY lasts exactly T_Y cycles.
REQ-017 SHALL hold S_START for exactly 1 cycle (all-red), assert CR_Ena=1 during that cycle only, and then enter S_CRG.
REQ-018 SHALL transition S_CRG->S_CRY when expired, so that S_CRG lasts exactly T_CRG cycles.
REQ-019 SHALL transition S_CRY->S_HWG when expired, so that S_CRY lasts exactly T_Y cycles; S_HWG SHALL be entered with the counter loaded to T_HWG_MIN-1.
REQ-020 SHALL assert time_out only during the final (expired) cycle of S_CRG and of S_CRY; time_out SHALL be 0 in all other cycles.
REQ-021 SHALL decode time_out and CR_Ena from registered state and counter only, glitch-free and with no combinational path from car_det.
REQ-022 SHALL never assert CR_Ena and time_out in the same cycle.
REQ-023 SHALL drive HW_LED=100 in S_HWG, 010 in S_HWY, and 001 in S_START, S_CRG and S_CRY.
REQ-024 SHALL leave HW_LED green until the next car_req, with no extra delay, when car_req is already set as minimum green expires.
REQ-025 SHALL re-latch car_req after returning to S_HWG if a car is still present, and restart the cycle once T_HWG_MIN has elapsed.
REQ-026 SHALL treat any illegal state code as S_HWG, reloading the counter to T_HWG_MIN-1 and clearing car_req.

Reset
REQ-027 SHALL, while rst_n==0 and asynchronously, force state S_HWG, counter T_HWG_MIN-1, car_req=0, synchroniser flops=0, HW_LED=100, CR_Ena=0, time_out=0 and phase=0.
REQ-028 SHALL apply REQ-027 on a reset asserted mid-sequence (any state), with no further strobes emitted, and SHALL restart from S_HWG after release.

Structure
REQ-029 SHALL place the LED encodings (GREEN/YELLOW/RED), the state codes and the default timing constants in shared package tl_pkg, for use also by the country-road controller.
REQ-030 SHALL implement the loadable saturating down-counter as sub-module phase_timer (inputs: load, load_val[7:0]; output: expired).

Verification
REQ-031 SHALL cover idle with no car: car_det=0 for 200 cycles after reset -> HW_LED=100 throughout, CR_Ena=0, time_out=0.
REQ-032 SHALL cover early car: car_det high from cycle 2 -> HW_LED=010 from cycle 16 for 4 cycles, CR_Ena pulse at cycle 20, time_out pulses at cycles 28 and 32, HW_LED=100 at cycle 33.
REQ-033 SHALL cover late car: car_det rises at cycle 50 -> car_req set at cycle 52, HW_LED goes yellow at cycle 53, CR_Ena pulse exactly 4 cycles later.
REQ-034 SHALL cover a persistent car: car_det held high -> full sequences repeat with period 16+4+1+8+4=33 cycles.
REQ-035 SHALL cover reset in S_CRG: assert rst_n=0 at the 3rd cycle of S_CRG -> immediate HW_LED=100 with no time_out pulse, then normal cycle after release.
REQ-036 SHALL cover a paired CR-controller model: check that CR lamps show red whenever HW_LED is not red, and that no cycle has both roads non-red.

Source files
------------

// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tl_pkg
//  Brief    : Shared traffic-light definitions: lamp encodings, scheduler
//             state codes, default phase durations and a lamp decode helper.
//  Revision : 1.0  initial release
// ============================================================================
package tl_pkg;

    // One-hot lamp encodings, shared by highway and country-road controllers
    localparam logic [2:0] GREEN  = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b001;

    // Default phase durations in clock cycles
    localparam int C_T_HWG_MIN = 16;
    localparam int C_T_Y       = 4;
    localparam int C_T_CRG     = 8;

    // Scheduler state codes; these are also exported on the debug phase port
    typedef enum logic [2:0] {
        S_HWG   = 3'd0,
        S_HWY   = 3'd1,
        S_START = 3'd2,
        S_CRG   = 3'd3,
        S_CRY   = 3'd4
    } state_t;

    // Highway lamp shown in a given state; unknown codes fall back to green
    function automatic logic [2:0] hw_led_for(state_t s);
        case (s)
            S_HWY:                return YELLOW;
            S_START, S_CRG, S_CRY: return RED;
            default:              return GREEN;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : phase_timer
//  Brief    : Loadable 8-bit down-counter that saturates at zero. expired is
//             high while the count is zero; expiring is high when the count
//             will be zero next cycle unless a load intervenes.
//  Revision : 1.0  initial release
// ============================================================================
module phase_timer #(
    parameter logic [7:0] RESET_VAL = 8'd15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expired,
    output logic       expiring
);

    logic [7:0] r_count;

    // Count register: load wins, otherwise decrement and hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= RESET_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign expired  = (r_count == 8'd0);
    assign expiring = (r_count <= 8'd1);

endmodule
`default_nettype wire

// File: rtl/intersection_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : intersection_scheduler
//  Brief    : Highway / country-road intersection scheduler. Keeps the
//             highway green for at least T_HWG_MIN cycles, and when a
//             country-road car has been seen, sequences yellow, an all-red
//             start cycle, country-road green and country-road yellow.
//             All outputs are registered and derived from the next state,
//             so they are glitch-free and have no path from car_det.
//  Revision : 1.0  initial release
// ============================================================================
module intersection_scheduler
    import tl_pkg::*;
#(
    parameter int T_HWG_MIN = C_T_HWG_MIN,
    parameter int T_Y       = C_T_Y,
    parameter int T_CRG     = C_T_CRG
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       car_det,
    output logic [2:0] HW_LED,
    output logic       CR_Ena,
    output logic       time_out,
    output logic [2:0] phase
);

    localparam logic [7:0] C_LD_HWG = 8'(T_HWG_MIN - 1);
    localparam logic [7:0] C_LD_Y   = 8'(T_Y - 1);
    localparam logic [7:0] C_LD_CRG = 8'(T_CRG - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_sync1;
    logic       r_car_s;
    logic       r_car_req;
    logic       w_car_req;
    logic       w_load;
    logic [7:0] w_load_val;
    logic       w_expired;
    logic       w_expiring;
    logic       w_clr_req;
    logic       w_next_zero;
    logic [2:0] r_hw_led;
    logic       r_cr_ena;
    logic       r_time_out;

    // Two-flop synchroniser for the asynchronous vehicle sensor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_car_s <= 1'b0;
        end else begin
            r_sync1 <= car_det;
            r_car_s <= r_sync1;
        end
    end

    // A car seen this cycle counts immediately, so an already-expired
    // minimum green advances without waiting for the request flop
    assign w_car_req = r_car_req | ((r_state == S_HWG) & r_car_s);

    phase_timer #(
        .RESET_VAL (C_LD_HWG)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .expired  (w_expired),
        .expiring (w_expiring)
    );

    // Next-state and timer-load decode; illegal codes recover to S_HWG
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = 8'd0;
        w_clr_req    = 1'b0;
        case (r_state)
            S_HWG: begin
                if (w_expired && w_car_req) begin
                    w_state_next = S_HWY;
                    w_load       = 1'b1;
                    w_load_val   = C_LD_Y;
                end
            end
            S_HWY: begin
                if (w_expired) begin
                    w_state_next = S_START;
                    w_load       = 1'b1;
                    w_clr_req    = 1'b1;
                end
            end
            S_START: begin
                w_state_next = S_CRG;
                w_load       = 1'b1;
                w_load_val   = C_LD_CRG;
            end
            S_CRG: begin
                if (w_expired) begin
                    w_state_next = S_CRY;
                    w_load       = 1'b1;
                    w_load_val   = C_LD_Y;
                end
            end
            S_CRY: begin
                if (w_expired) begin
                    w_state_next = S_HWG;
                    w_load       = 1'b1;
                    w_load_val   = C_LD_HWG;
                end
            end
            default: begin
                w_state_next = S_HWG;
                w_load       = 1'b1;
                w_load_val   = C_LD_HWG;
                w_clr_req    = 1'b1;
            end
        endcase
    end

    // Counter value in the next cycle is zero: either a zero load, or the
    // free-running count is about to reach zero
    assign w_next_zero = w_load ? (w_load_val == 8'd0) : w_expiring;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HWG;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request latch: set by a car during highway green, cleared entering start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_car_req <= 1'b0;
        end else if (w_clr_req) begin
            r_car_req <= 1'b0;
        end else if (r_state == S_HWG && r_car_s) begin
            r_car_req <= 1'b1;
        end
    end

    // Registered outputs, computed one cycle ahead from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hw_led   <= GREEN;
            r_cr_ena   <= 1'b0;
            r_time_out <= 1'b0;
        end else begin
            r_hw_led   <= hw_led_for(w_state_next);
            r_cr_ena   <= (w_state_next == S_START);
            r_time_out <= ((w_state_next == S_CRG) || (w_state_next == S_CRY))
                          && w_next_zero;
        end
    end

    assign HW_LED   = r_hw_led;
    assign CR_Ena   = r_cr_ena;
    assign time_out = r_time_out;
    assign phase    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_intersection_scheduler
//  Brief    : Directed self-checking bench for intersection_scheduler with a
//             paired country-road lamp model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_intersection_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       car_det = 1'b0;
    logic [2:0] HW_LED;
    logic       CR_Ena;
    logic       time_out;
    logic [2:0] phase;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int cr_st  = 0;   // paired country-road lamp: 0 red, 1 green, 2 yellow

    intersection_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .car_det  (car_det),
        .HW_LED   (HW_LED),
        .CR_Ena   (CR_Ena),
        .time_out (time_out),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Position within a highway-yellow-started sequence, -1 when none
    function automatic int seq_pos(int c, int y, bit rep);
        int p;
        if (y < 0 || c < y) return -1;
        p = c - y;
        if (rep) p = p % 33;
        return p;
    endfunction

    function automatic logic [7:0] exp_phase(int p);
        if (p < 0)   return 8'd0;
        if (p <= 3)  return 8'd1;
        if (p == 4)  return 8'd2;
        if (p <= 12) return 8'd3;
        if (p <= 16) return 8'd4;
        return 8'd0;
    endfunction

    function automatic logic [7:0] exp_led(int p);
        logic [7:0] ph;
        ph = exp_phase(p);
        if (ph == 8'd0) return 8'b100;
        if (ph == 8'd1) return 8'b010;
        return 8'b001;
    endfunction

    task automatic check_cycle(input int y, input bit rep);
        int p;
        p = seq_pos(cyc, y, rep);
        chk("hw_led",   8'(HW_LED),   exp_led(p));
        chk("phase",    8'(phase),    exp_phase(p));
        chk("cr_ena",   8'(CR_Ena),   (p == 4) ? 8'd1 : 8'd0);
        chk("time_out", 8'(time_out), (p == 12 || p == 16) ? 8'd1 : 8'd0);
    endtask

    // Advance one clock: the CR model consumes this cycle's strobes, then
    // the pairing rule is checked on the new cycle
    task automatic next_cycle();
        if (CR_Ena)                      cr_st = 1;
        else if (time_out && cr_st == 1) cr_st = 2;
        else if (time_out && cr_st == 2) cr_st = 0;
        @(negedge clk);
        cyc++;
        chk("both_nonred", ((HW_LED !== 3'b001) && (cr_st != 0)) ? 8'd1 : 8'd0, 8'd0);
    endtask

    task automatic run(input int n, input int y, input bit rep, input int on_c, input int off_c);
        for (int i = 0; i < n; i++) begin
            if (cyc == on_c)  car_det = 1'b1;
            if (cyc == off_c) car_det = 1'b0;
            check_cycle(y, rep);
            next_cycle();
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        car_det = 1'b0;
        cr_st   = 0;
        @(negedge clk);
        chk("rst_led",      8'(HW_LED),   8'b100);
        chk("rst_phase",    8'(phase),    8'd0);
        chk("rst_cr_ena",   8'(CR_Ena),   8'd0);
        chk("rst_time_out", 8'(time_out), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        // Idle: no car for 200 cycles, highway stays green, no strobes
        do_reset();
        run(200, -1, 1'b0, -1, -1);

        // Early car from cycle 2: yellow 16..19, CR_Ena 20, time_out 28/32, green 33
        do_reset();
        run(41, 16, 1'b0, 2, 10);

        // Late car at cycle 50: yellow 53, CR_Ena 57
        do_reset();
        run(76, 53, 1'b0, 50, 55);

        // Persistent car: sequence repeats every 33 cycles
        do_reset();
        run(120, 16, 1'b1, 0, -1);

        // Reset during the 3rd cycle of country-road green
        do_reset();
        run(23, 16, 1'b0, 2, 10);
        chk("crg_before_rst", 8'(phase), 8'd3);
        rst_n   = 1'b0;
        car_det = 1'b0;
        cr_st   = 0;
        #1;
        chk("mid_rst_led",      8'(HW_LED),   8'b100);
        chk("mid_rst_phase",    8'(phase),    8'd0);
        chk("mid_rst_cr_ena",   8'(CR_Ena),   8'd0);
        chk("mid_rst_time_out", 8'(time_out), 8'd0);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            chk("in_rst_time_out", 8'(time_out), 8'd0);
            chk("in_rst_cr_ena",   8'(CR_Ena),   8'd0);
            chk("in_rst_led",      8'(HW_LED),   8'b100);
        end
        rst_n = 1'b1;
        cyc   = 0;
        run(41, 16, 1'b0, 2, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
